// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// baud divider computation used by both the RX and TX paths.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } rx_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clock_rate, input int baud_rate,
                                  input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clocks, with a
// synchronous restart so the tick phase can be aligned to a start edge.
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));

  // Divider counter; restart and reset both return it to zero.
  always_ff @(posedge clk) begin
    if (rst || i_restart) r_cnt <= '0;
    else if (w_wrap)      r_cnt <= '0;
    else                  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = w_wrap && !i_restart;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample
// majority vote at bit centre, optional parity, 1 or 2 stop bits, and
// break detection with a wait for the line to return high.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic                 rxBreak,
  output logic [DATA_BITS-1:0] rxOut
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);

  // Handshake: rxDone is a single-clk valid strobe with no ready; rxOut and
  // the error flags are stable from that clk until the next accepted start.

  rx_state_t              r_state, w_next;
  logic                   r_sync1, r_sync2, r_prev;
  logic [TW-1:0]          r_tick_cnt;
  logic [3:0]             r_bit_cnt;
  logic                   r_s0, r_s1;
  logic [DATA_BITS-1:0]   r_shift, r_out;
  logic                   r_par_flag, r_frm_flag, r_par_lo, r_stop0_lo;
  logic                   r_done, r_err, r_perr, r_brk;

  logic w_rx, w_edge, w_tick, w_start_take, w_maj;
  logic w_samp0, w_samp1, w_decide, w_bit_end;
  logic w_last_data, w_last_stop, w_stop0_lo, w_break, w_complete, w_par_exp;

  assign w_rx         = r_sync2;
  assign w_edge       = r_prev && !r_sync2;
  assign w_start_take = (r_state == S_IDLE) && rxEn && w_edge;
  assign w_samp0      = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign w_samp1      = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2));
  assign w_decide     = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2 + 1));
  assign w_bit_end    = w_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
  assign w_maj        = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_last_data  = (r_bit_cnt == 4'(DATA_BITS - 1));
  assign w_last_stop  = (r_bit_cnt == 4'(STOP_BITS - 1));
  assign w_stop0_lo   = (r_bit_cnt == 4'd0) ? !w_maj : r_stop0_lo;
  assign w_break      = (r_shift == '0) && ((PARITY == PAR_NONE) || r_par_lo) && w_stop0_lo;
  assign w_complete   = rxEn && (r_state == S_STOP) && w_decide && w_last_stop;
  assign w_par_exp    = (^r_shift) ^ (PARITY == PAR_ODD);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_restart(w_start_take),
    .o_tick   (w_tick)
  );

  // Synchroniser plus one history flop for falling-edge detection; resets
  // low so a start needs a high to have been seen first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rxIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; disabling the receiver always returns to IDLE.
  always_comb begin
    w_next = r_state;
    if (!rxEn) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_edge) w_next = S_START;
        S_START:   if (w_decide && w_maj) w_next = S_IDLE;
                   else if (w_bit_end) w_next = S_DATA;
        S_DATA:    if (w_bit_end && w_last_data)
                     w_next = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
        S_PARITY:  if (w_bit_end) w_next = S_STOP;
        S_STOP:    if (w_decide && w_last_stop) w_next = w_break ? S_BRKWAIT : S_IDLE;
        S_BRKWAIT: if (w_tick && w_rx && (r_tick_cnt == TW'(OVERSAMPLE - 1))) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: tick/bit counters, majority samples, shift register and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_shift    <= '0;
      r_out      <= '0;
      r_par_flag <= 1'b0;
      r_frm_flag <= 1'b0;
      r_par_lo   <= 1'b0;
      r_stop0_lo <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_perr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_take) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_par_flag <= 1'b0;
        r_frm_flag <= 1'b0;
        r_par_lo   <= 1'b0;
        r_stop0_lo <= 1'b0;
        r_err      <= 1'b0;
        r_perr     <= 1'b0;
        r_brk      <= 1'b0;
      end else if (rxEn) begin
        if (r_state == S_BRKWAIT) begin
          if (!w_rx)       r_tick_cnt <= '0;
          else if (w_tick) r_tick_cnt <= r_tick_cnt + 1'b1;
        end else if ((r_state != S_IDLE) && w_tick) begin
          r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
        end
        if (w_samp0) r_s0 <= w_rx;
        if (w_samp1) r_s1 <= w_rx;
        if (w_bit_end) begin
          if (r_state == S_DATA)      r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
          else if (r_state == S_STOP) r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        if (w_decide) begin
          case (r_state)
            S_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            S_PARITY: begin
              r_par_lo <= !w_maj;
              if (w_maj != w_par_exp) r_par_flag <= 1'b1;
            end
            S_STOP: begin
              if (!w_maj) r_frm_flag <= 1'b1;
              if (r_bit_cnt == 4'd0) r_stop0_lo <= !w_maj;
            end
            default: ;
          endcase
        end
        if (w_complete) begin
          r_done     <= 1'b1;
          r_out      <= w_break ? '0 : r_shift;
          r_err      <= r_frm_flag | !w_maj | w_break;
          r_perr     <= r_par_flag;
          r_brk      <= w_break;
          r_tick_cnt <= '0;
        end
      end
    end
  end

  assign rxBusy      = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
  assign rxDone      = r_done;
  assign rxErr       = r_err;
  assign rxParityErr = r_perr;
  assign rxBreak     = r_brk;
  assign rxOut       = r_out;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1 defaults, 7E1 fast,
// 8N2 fast) driven by serial-line tasks; a frame-level model predicts each
// completed word and its flags, and a negedge monitor checks every rxDone.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int FAST_CLK = 614400;            // 614400/(9600*16) = 4 clk per tick
  localparam int DB[3] = '{8, 7, 8};
  localparam int PM[3] = '{PAR_NONE, PAR_EVEN, PAR_NONE};
  localparam int SB[3] = '{1, 1, 2};
  localparam int BP[3] = '{1248, 64, 64};      // 78*16 and 4*16 clk per bit

  typedef struct {
    logic [8:0] data;
    logic       err;
    logic       perr;
    logic       brk;
    int         lo;
    int         hi;
  } exp_t;

  logic       clk;
  logic [2:0] rst_v, en_v, rx_v;
  logic [2:0] busy_v, done_v, err_v, perr_v, brk_v, done_d;
  logic [7:0] out_a, out_c;
  logic [6:0] out_b;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errs = 0;
  exp_t       exp_q0[$], exp_q1[$], exp_q2[$];

  uart_rx_param u_a (
    .clk(clk), .rst(rst_v[0]), .rxEn(en_v[0]), .rxIn(rx_v[0]), .rxBusy(busy_v[0]),
    .rxDone(done_v[0]), .rxErr(err_v[0]), .rxParityErr(perr_v[0]), .rxBreak(brk_v[0]),
    .rxOut(out_a));

  uart_rx_param #(.CLOCK_RATE(FAST_CLK), .DATA_BITS(7), .PARITY(PAR_EVEN)) u_b (
    .clk(clk), .rst(rst_v[1]), .rxEn(en_v[1]), .rxIn(rx_v[1]), .rxBusy(busy_v[1]),
    .rxDone(done_v[1]), .rxErr(err_v[1]), .rxParityErr(perr_v[1]), .rxBreak(brk_v[1]),
    .rxOut(out_b));

  uart_rx_param #(.CLOCK_RATE(FAST_CLK), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst_v[2]), .rxEn(en_v[2]), .rxIn(rx_v[2]), .rxBusy(busy_v[2]),
    .rxDone(done_v[2]), .rxErr(err_v[2]), .rxParityErr(perr_v[2]), .rxBreak(brk_v[2]),
    .rxOut(out_c));

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] get_out(input int i);
    case (i)
      0:       return {1'b0, out_a};
      1:       return {2'b0, out_b};
      default: return {1'b0, out_c};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on instance i and, if wanted, queue the predicted result.
  task automatic send_frame(input int i, input logic [8:0] data, input logic par_bad,
                            input logic [1:0] stop_lo, input int gap, input logic expect_it);
    logic [8:0] d;
    logic       pbit;
    exp_t       e;
    int         nb;
    d    = data & ((9'd1 << DB[i]) - 9'd1);
    pbit = (^d) ^ (PM[i] == PAR_ODD) ^ par_bad;
    nb   = 1 + DB[i] + ((PM[i] != PAR_NONE) ? 1 : 0) + SB[i];
    e.data = d;
    e.perr = par_bad && (PM[i] != PAR_NONE);
    e.brk  = (d == 9'd0) && ((PM[i] == PAR_NONE) || !pbit) && stop_lo[0];
    e.err  = stop_lo[0] || ((SB[i] == 2) && stop_lo[1]) || e.brk;
    e.lo   = cyc + (nb - 1) * BP[i] + BP[i] / 2;
    e.hi   = cyc + (nb - 1) * BP[i] + (3 * BP[i]) / 4;
    if (expect_it) begin
      case (i)
        0:       exp_q0.push_back(e);
        1:       exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
    rx_v[i] = 1'b0;
    wait_clk(BP[i]);
    for (int b = 0; b < DB[i]; b++) begin
      rx_v[i] = d[b];
      wait_clk(BP[i]);
    end
    if (PM[i] != PAR_NONE) begin
      rx_v[i] = pbit;
      wait_clk(BP[i]);
    end
    for (int s = 0; s < SB[i]; s++) begin
      rx_v[i] = !stop_lo[s];
      wait_clk(BP[i]);
    end
    rx_v[i] = 1'b1;
    wait_clk(gap * BP[i]);
  endtask

  // Monitor: every rxDone must match the oldest predicted frame, land in its
  // time window and be exactly one clock wide.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        have = 1'b0;
        case (i)
          0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
          1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_done[%0d]: got done at cycle %0d want none", i, cyc);
        end else begin
          check($sformatf("rxOut[%0d]", i), 32'(get_out(i)), 32'(e.data));
          check($sformatf("rxErr[%0d]", i), 32'(err_v[i]), 32'(e.err));
          check($sformatf("rxParityErr[%0d]", i), 32'(perr_v[i]), 32'(e.perr));
          check($sformatf("rxBreak[%0d]", i), 32'(brk_v[i]), 32'(e.brk));
          n_checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_errs++;
            $display("FAIL done_time[%0d]: got %0d want %0d..%0d", i, cyc, e.lo, e.hi);
          end
        end
        check($sformatf("done_width[%0d]", i), 32'(done_d[i]), 32'd0);
      end
    end
    done_d <= done_v;
  end

  // Main stimulus
  initial begin
    logic [8:0] d;
    logic       pb;
    logic [1:0] sl;
    int         gap;
    rst_v  = 3'b111;
    en_v   = 3'b111;
    rx_v   = 3'b111;
    done_d = 3'b000;
    wait_clk(5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst_flags[%0d]", i), 32'({err_v[i], perr_v[i], brk_v[i]}), 32'd0);
      check($sformatf("rst_out[%0d]", i), 32'(get_out(i)), 32'd0);
    end
    rst_v = 3'b000;
    wait_clk(5);

    // 8N1 defaults: 0x35, then a 3-tick low glitch (false start)
    send_frame(0, 9'h35, 1'b0, 2'b00, 1, 1'b1);
    check("a_out_35", 32'(out_a), 32'h35);
    check("a_flags_35", 32'({err_v[0], perr_v[0], brk_v[0]}), 32'd0);
    rx_v[0] = 1'b0;
    wait_clk(20);
    check("a_glitch_busy_hi", 32'(busy_v[0]), 32'd1);
    wait_clk(3 * 78 - 20);
    rx_v[0] = 1'b1;
    wait_clk(BP[0]);
    check("a_glitch_busy_lo", 32'(busy_v[0]), 32'd0);
    check("a_glitch_out_held", 32'(out_a), 32'h35);

    // 7E1: wrong parity then correct parity
    send_frame(1, 9'h55, 1'b1, 2'b00, 1, 1'b1);
    check("b_out_55", 32'(out_b), 32'h55);
    check("b_perr_55", 32'(perr_v[1]), 32'd1);
    send_frame(1, 9'h2A, 1'b0, 2'b00, 1, 1'b1);
    check("b_out_2a", 32'(out_b), 32'h2A);
    check("b_perr_2a", 32'(perr_v[1]), 32'd0);

    // 8N2: second stop low, then clean frames including a zero-gap pair
    send_frame(2, 9'hA5, 1'b0, 2'b10, 1, 1'b1);
    check("c_out_a5", 32'(out_c), 32'hA5);
    check("c_err_a5", 32'(err_v[2]), 32'd1);
    send_frame(2, 9'h5A, 1'b0, 2'b00, 0, 1'b1);
    check("c_out_5a", 32'(out_c), 32'h5A);
    check("c_err_5a", 32'(err_v[2]), 32'd0);
    send_frame(2, 9'h3C, 1'b0, 2'b00, 1, 1'b1);
    check("c_out_3c", 32'(out_c), 32'h3C);

    // Break: line low for three frame times, then 0x01 after the line recovers
    begin
      exp_t e;
      e.data = 9'd0; e.err = 1'b1; e.perr = 1'b0; e.brk = 1'b1;
      e.lo = cyc + 10 * BP[2] + BP[2] / 2;
      e.hi = cyc + 10 * BP[2] + (3 * BP[2]) / 4;
      exp_q2.push_back(e);
    end
    rx_v[2] = 1'b0;
    wait_clk(33 * BP[2]);
    check("c_brk_out", 32'(out_c), 32'd0);
    check("c_brk_flags", 32'({brk_v[2], err_v[2], busy_v[2]}), 32'b110);
    rx_v[2] = 1'b1;
    wait_clk(2 * BP[2]);
    send_frame(2, 9'h01, 1'b0, 2'b00, 1, 1'b1);
    check("c_out_01", 32'(out_c), 32'h01);
    check("c_flags_01", 32'({brk_v[2], err_v[2]}), 32'd0);

    // rst during data bit 4: no completion, all outputs zero
    fork
      send_frame(2, 9'h0F, 1'b0, 2'b00, 2, 1'b0);
      begin
        wait_clk(5 * BP[2] + BP[2] / 2);
        rst_v[2] = 1'b1;
        wait_clk(3);
        check("c_rst_out", 32'(out_c), 32'd0);
        check("c_rst_flags", 32'({busy_v[2], done_v[2], err_v[2], perr_v[2], brk_v[2]}), 32'd0);
        rst_v[2] = 1'b0;
      end
    join
    // rxEn dropped mid-frame: no completion, busy falls, rxOut held
    fork
      send_frame(2, 9'hC3, 1'b0, 2'b00, 2, 1'b0);
      begin
        wait_clk(4 * BP[2] + 10);
        check("c_en_busy_before", 32'(busy_v[2]), 32'd1);
        en_v[2] = 1'b0;
        wait_clk(2);
        check("c_en_busy_after", 32'(busy_v[2]), 32'd0);
        check("c_en_out_held", 32'(out_c), 32'd0);
      end
    join
    en_v[2] = 1'b1;
    wait_clk(4);
    send_frame(2, 9'hFF, 1'b0, 2'b00, 1, 1'b1);
    check("c_out_ff", 32'(out_c), 32'hFF);

    // Randomized frames on the fast instances
    for (int n = 0; n < 24; n++) begin
      int i;
      i   = (n % 2 == 0) ? 1 : 2;
      d   = ($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      pb  = ($urandom_range(0, 3) == 0);
      sl  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (SB[i] == 1) sl[1] = 1'b0;
      gap = (sl != 2'b00) ? 3 : $urandom_range(0, 2);
      send_frame(i, d, pb, sl, gap, 1'b1);
    end

    wait_clk(2 * BP[0]);
    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    check("q2_empty", 32'(exp_q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count; 16x oversampling (parametrisable); 3-sample majority vote at bit centre.
- Detects false starts, framing errors, parity errors and line break.
- Sits between the board RX pin and the byte-consumer logic; same clock domain as the transmitter.

Parameters:
CLOCK_RATE, 12000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, ticks per bit, even, >= 8

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
rxEn  in  1  receiver enable
rxIn  in  1  asynchronous serial line, idle high
rxBusy  out  1  frame in progress
rxDone  out  1  one-clk pulse: frame complete, rxOut valid
rxErr  out  1  framing error (stop bit sampled low)
rxParityErr  out  1  parity mismatch
rxBreak  out  1  break condition detected
rxOut  out  DATA_BITS  received word, LSB first on line

Behaviour:
- Reset: all outputs 0, rxOut = 0, state IDLE, tick counter 0. rst mid-frame aborts immediately; no rxDone is emitted.
- Synchroniser: rxIn passes through 2 flops before use; total input latency is 2 clk.
- Tick generator:
  - DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE), integer truncation (78 at defaults).
  - One-clk tick every DIV clocks.
  - Restarts at 0 on start-edge detection so sampling phase aligns to the frame.
- FSM states: IDLE, START, DATA, PARITY (skipped when PARITY = 0), STOP, BRKWAIT.
- IDLE:
  - Requires rxEn = 1.
  - A synchronised high-to-low transition moves to START and sets rxBusy = 1.
- Bit sampling: in every bit state, samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the bit value is the majority of the three.
- START:
  - Majority 1: false start; return to IDLE, rxBusy = 0, no flags.
  - Majority 0: at tick OVERSAMPLE-1, go to DATA.
- DATA:
  - Shift DATA_BITS bits, LSB first, into the shift register.
  - Go to PARITY or STOP after the last bit.
- PARITY:
  - Computed bit is XOR of the data bits, inverted for odd parity.
  - A mismatch latches the internal parity flag.
- STOP:
  - Each of the STOP_BITS bits is sampled.
  - Any low stop bit latches the framing flag.
  - Completion occurs at the centre sample of the last stop bit, not at the end of the bit, so back-to-back frames are not missed.
- Completion, on the same clk:
  - rxOut <= shift register.
  - rxDone = 1 for exactly one clk.
  - rxErr and rxParityErr are updated from the internal flags.
  - rxBusy = 0.
  - rxErr and rxParityErr then hold until the next accepted start bit clears them.
- Break: data = 0, parity sample 0 (if enabled) and the first stop bit 0 together cause:
  - rxBreak = 1, rxErr = 1, rxDone still pulses, rxOut = 0.
  - Transition to BRKWAIT.
  - BRKWAIT stays until the line has been high for one full bit time, then enters IDLE.
  - rxBreak clears on the next start bit.
- rxEn deasserted in any state:
  - Next clk is IDLE with rxBusy = 0.
  - No rxDone; rxOut and error flags are held.
- Line still low when entering IDLE (e.g. after a framing error): no start is taken until a high has been observed.
- Simultaneous rst and start edge: rst wins.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
  - rx FSM state enum
  - a DIV computation function shared with the transmitter
- Sub-module uart_baud_tick: the divider with sync restart input and tick output, reusable by the TX path.
- Synchroniser, FSM, shift register and flags stay in uart_rx_param.

Test Plan:
- Defaults (8N1, 12 MHz, 9600), bit period 1248 clk, send 0x35 -> rxDone pulses once, 1 clk wide, about 9.5 bit times after the start edge; rxOut = 8'h35; rxErr = rxParityErr = rxBreak = 0.
- Low glitch of 3 bit-ticks on idle line -> false start; rxBusy rises then falls, no rxDone, rxOut unchanged.
- DATA_BITS = 7, PARITY = 2 (even), send 7'h55 with parity 1 (wrong) -> rxOut = 7'h55, rxDone pulses, rxParityErr = 1; next correct frame 7'h2A with parity 1 -> rxParityErr = 0.
- STOP_BITS = 2, second stop bit driven low, value 0xA5 -> rxOut = 8'hA5, rxErr = 1; back-to-back second frame 0x5A with gap 0 -> received 8'h5A, rxErr = 0.
- Line held low 3 frame times -> exactly one rxDone with rxOut = 0, rxBreak = rxErr = 1; no further rxDone until line high for 1 bit; the following frame 0x01 is received cleanly.
- rst asserted at data bit 4 of a frame, then rxEn toggled low mid-frame in a second frame -> all outputs 0 after rst, no rxDone for either aborted frame; the third frame 0xFF is received correctly.
